// File: rtl/scoreboard_issue_ctrl.sv
// In-order single-issue scoreboard: tracks pending register writes and per-unit
// busy state, stalls on RAW/WAW/structural hazards, issues registered pulses.
module scoreboard_issue_ctrl #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_alu,
  input  logic             dec_mul,
  input  logic             dec_lsu,
  input  logic             dec_imm,
  input  logic             dec_store,
  input  logic [5:0]       dec_ex_type,
  output logic             iss_alu_valid,
  output logic             iss_mul_valid,
  output logic             iss_lsu_valid,
  output logic [4:0]       iss_rs1,
  output logic [4:0]       iss_rs2,
  output logic [4:0]       iss_rd,
  output logic             iss_imm,
  output logic [5:0]       iss_ex_type,
  input  logic             alu_done,
  input  logic             mul_done,
  input  logic             lsu_done,
  output logic [NREG-1:0]  pending,
  output logic [2:0]       unit_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} ustate_t;

  ustate_t         state_q [3];
  ustate_t         state_d [3];
  logic [2:0][4:0] urd_q;
  logic [2:0]      uwr_q;
  logic [2:0]      iss_v_q;
  logic [NREG-1:0] pend_d;

  logic [2:0] sel, done;
  logic       use_rs2, writes_rd, raw, waw, busy_hit, accept;

  assign sel  = {dec_lsu, dec_mul, dec_alu};
  assign done = {lsu_done, mul_done, alu_done};

  // Loads use the rs2 field as don't-care; pending[0] is never set, so x0 never hazards.
  assign use_rs2   = ~dec_imm & ~(dec_lsu & ~dec_store);
  assign writes_rd = ~dec_store & (dec_rd != 5'd0) & (|sel);
  assign raw       = pending[dec_rs1] | (use_rs2 & pending[dec_rs2]);
  assign waw       = writes_rd & pending[dec_rd];
  assign busy_hit  = |(sel & unit_busy);
  assign dec_ready = ~flush & ~raw & ~waw & ~busy_hit;
  assign accept    = dec_valid & dec_ready;

  assign iss_alu_valid = iss_v_q[0];
  assign iss_mul_valid = iss_v_q[1];
  assign iss_lsu_valid = iss_v_q[2];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i]   = state_q[i];
      unit_busy[i] = (state_q[i] == BUSY);
      case (state_q[i])
        IDLE: if (accept && sel[i]) state_d[i] = BUSY;
        BUSY: if (done[i])          state_d[i] = IDLE;
        default:                    state_d[i] = IDLE;
      endcase
      if (flush) state_d[i] = IDLE;
    end
  end

  // Clears before set: WAW guarantees a retiring rd never equals the new rd.
  always_comb begin
    pend_d = pending;
    for (int i = 0; i < 3; i++)
      if (state_q[i] == BUSY && done[i] && uwr_q[i]) pend_d[urd_q[i]] = 1'b0;
    if (accept && writes_rd) pend_d[dec_rd] = 1'b1;
    if (flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) state_q[i] <= IDLE;
      urd_q       <= '0;
      uwr_q       <= '0;
      iss_v_q     <= '0;
      pending     <= '0;
      iss_rs1     <= '0;
      iss_rs2     <= '0;
      iss_rd      <= '0;
      iss_imm     <= 1'b0;
      iss_ex_type <= '0;
      stall_cnt   <= '0;
      issue_cnt   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        if (accept && sel[i]) begin
          urd_q[i] <= dec_rd;
          uwr_q[i] <= writes_rd;
        end
      end
      if (flush) begin
        urd_q <= '0;
        uwr_q <= '0;
      end
      pending <= pend_d;
      iss_v_q <= {3{accept}} & sel;
      if (accept) begin
        iss_rs1     <= dec_rs1;
        iss_rs2     <= dec_rs2;
        iss_rd      <= dec_rd;
        iss_imm     <= dec_imm;
        iss_ex_type <= dec_ex_type;
      end
      if (dec_valid && !dec_ready && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (accept && (|sel) && issue_cnt != '1)
        issue_cnt <= issue_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_scoreboard_issue_ctrl.sv
// Directed bench for scoreboard_issue_ctrl; expected issues are queued when
// driven and compared by a monitor when an issue pulse appears.
module tb_scoreboard_issue_ctrl;
  localparam int NREG = 32, CNT_W = 16;

  logic clk = 1'b0, rst, flush, dec_valid, dec_ready;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic dec_alu, dec_mul, dec_lsu, dec_imm, dec_store;
  logic [5:0] dec_ex_type;
  logic iss_alu_valid, iss_mul_valid, iss_lsu_valid;
  logic [4:0] iss_rs1, iss_rs2, iss_rd;
  logic iss_imm;
  logic [5:0] iss_ex_type;
  logic alu_done, mul_done, lsu_done;
  logic [NREG-1:0] pending;
  logic [2:0] unit_busy;
  logic [CNT_W-1:0] stall_cnt, issue_cnt;

  int n_chk = 0, n_err = 0;
  logic [24:0] exp_q [$];
  logic [CNT_W-1:0] s0;

  scoreboard_issue_ctrl #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_alu(dec_alu), .dec_mul(dec_mul), .dec_lsu(dec_lsu),
    .dec_imm(dec_imm), .dec_store(dec_store), .dec_ex_type(dec_ex_type),
    .iss_alu_valid(iss_alu_valid), .iss_mul_valid(iss_mul_valid), .iss_lsu_valid(iss_lsu_valid),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_imm(iss_imm),
    .iss_ex_type(iss_ex_type), .alu_done(alu_done), .mul_done(mul_done), .lsu_done(lsu_done),
    .pending(pending), .unit_busy(unit_busy), .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREG-1:0] regs(input int a, input int b = 0, input int c = 0);
    logic [NREG-1:0] m = '0;
    if (a != 0) m[a] = 1'b1;
    if (b != 0) m[b] = 1'b1;
    if (c != 0) m[c] = 1'b1;
    return m;
  endfunction

  // Monitor: every issue pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [2:0] v;
    v = {iss_lsu_valid, iss_mul_valid, iss_alu_valid};
    if (v != 3'b000) begin
      if (exp_q.size() == 0) chk("unexpected_issue", 64'(v), 64'd0);
      else chk("issue", 64'({v, iss_rs1, iss_rs2, iss_rd, iss_imm, iss_ex_type}),
               64'(exp_q.pop_front()));
    end
  end

  task automatic cyc();
    @(negedge clk);
    dec_valid = 1'b0; flush = 1'b0;
    alu_done = 1'b0; mul_done = 1'b0; lsu_done = 1'b0;
    dec_alu = 1'b0; dec_mul = 1'b0; dec_lsu = 1'b0;
    dec_imm = 1'b0; dec_store = 1'b0;
  endtask

  // Drive a decoded instruction in the current cycle and check dec_ready.
  task automatic issue(input string tag, input logic [2:0] u, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic imm,
                       input logic store, input logic [5:0] ex, input logic exp_rdy);
    {dec_lsu, dec_mul, dec_alu} = u;
    dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_imm = imm; dec_store = store; dec_ex_type = ex;
    dec_valid = 1'b1;
    #1;
    chk(tag, 64'(dec_ready), 64'(exp_rdy));
    if (exp_rdy && !flush && u != 3'b000) exp_q.push_back({u, rs1, rs2, rd, imm, ex});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_ex_type = '0;
    cyc(); cyc();
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_busy", 64'(unit_busy), 64'd0);
    chk("rst_cnt", 64'({stall_cnt, issue_cnt}), 64'd0);
    chk("rst_iss", 64'({iss_alu_valid, iss_mul_valid, iss_lsu_valid, iss_rs1, iss_rs2, iss_rd,
                        iss_imm, iss_ex_type}), 64'd0);
    rst = 1'b0;

    // Independent ALU op
    cyc(); issue("alu_rdy", 3'b001, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 6'd0, 1'b1);
    cyc();
    chk("alu_pulse", 64'(iss_alu_valid), 64'd1);
    chk("alu_pend", 64'(pending), 64'(regs(3)));
    chk("alu_busy", 64'(unit_busy), 64'd1);
    chk("issue_cnt", 64'(issue_cnt), 64'd1);
    cyc();
    chk("alu_pulse_once", 64'(iss_alu_valid), 64'd0);
    cyc(); alu_done = 1'b1;
    cyc();
    chk("alu_done_pend", 64'(pending), 64'd0);
    chk("alu_done_busy", 64'(unit_busy), 64'd0);

    // RAW on MUL rd=5
    cyc(); issue("mul_rdy", 3'b010, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 6'd2, 1'b1);
    s0 = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      cyc(); issue("raw_stall", 3'b001, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 6'd3, 1'b0);
    end
    cyc(); mul_done = 1'b1;
    issue("raw_done_cycle", 3'b001, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 6'd3, 1'b0);
    cyc(); issue("raw_release", 3'b001, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 6'd3, 1'b1);
    chk("raw_stall_cnt", 64'(stall_cnt), 64'(s0 + 16'd4));
    cyc();
    chk("raw_pend", 64'(pending), 64'(regs(6)));
    chk("raw_busy", 64'(unit_busy), 64'd1);
    alu_done = 1'b1;

    // WAW and structural on LSU
    cyc(); issue("ld7_rdy", 3'b100, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 6'd4, 1'b1);
    cyc(); issue("waw_block", 3'b001, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 6'd5, 1'b0);
    cyc(); issue("struct_block", 3'b100, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 6'd6, 1'b0);
    cyc(); lsu_done = 1'b1;
    cyc(); issue("waw_release", 3'b001, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 6'd5, 1'b1);
    cyc(); alu_done = 1'b1;

    // x0 and store/load rs2 handling
    cyc(); issue("x0_rdy", 3'b001, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 6'd7, 1'b1);
    cyc();
    chk("x0_pend", 64'(pending), 64'd0);
    alu_done = 1'b1;
    cyc(); issue("mul4_rdy", 3'b010, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0, 6'd8, 1'b1);
    cyc(); issue("store_block", 3'b100, 5'd1, 5'd4, 5'd0, 1'b0, 1'b1, 6'd9, 1'b0);
    cyc(); issue("load_rs2_ok", 3'b100, 5'd1, 5'd4, 5'd9, 1'b0, 1'b0, 6'd10, 1'b1);
    cyc();
    chk("load_pend", 64'(pending), 64'(regs(4, 9)));
    chk("load_busy", 64'(unit_busy), 64'b110);

    // Simultaneous dones and LSU accept
    lsu_done = 1'b1;
    cyc(); issue("alu3_rdy", 3'b001, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 6'd11, 1'b1);
    cyc();
    chk("pre_sim_busy", 64'(unit_busy), 64'b011);
    alu_done = 1'b1; mul_done = 1'b1;
    issue("sim_lsu_rdy", 3'b100, 5'd1, 5'd0, 5'd10, 1'b1, 1'b0, 6'd12, 1'b1);
    cyc();
    chk("sim_busy", 64'(unit_busy), 64'b100);
    chk("sim_pend", 64'(pending), 64'(regs(10)));
    lsu_done = 1'b1;

    // Flush with ALU and MUL busy
    cyc(); issue("fl_alu", 3'b001, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 6'd13, 1'b1);
    cyc(); issue("fl_mul", 3'b010, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 6'd14, 1'b1);
    cyc();
    chk("fl_pre_pend", 64'(pending), 64'(regs(3, 5)));
    chk("fl_pre_busy", 64'(unit_busy), 64'b011);
    s0 = stall_cnt;
    flush = 1'b1;
    issue("fl_ready", 3'b100, 5'd1, 5'd0, 5'd11, 1'b1, 1'b0, 6'd15, 1'b0);
    cyc();
    chk("fl_pend", 64'(pending), 64'd0);
    chk("fl_busy", 64'(unit_busy), 64'd0);
    chk("fl_no_pulse", 64'({iss_alu_valid, iss_mul_valid, iss_lsu_valid}), 64'd0);
    chk("fl_stall_cnt", 64'(stall_cnt), 64'(s0));
    mul_done = 1'b1;
    cyc();
    chk("late_done_busy", 64'(unit_busy), 64'd0);
    chk("late_done_pend", 64'(pending), 64'd0);

    // Reset mid-stall
    cyc(); issue("rs_mul", 3'b010, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 6'd16, 1'b1);
    cyc(); issue("rs_stall", 3'b001, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 6'd17, 1'b0);
    cyc(); issue("rs_stall2", 3'b001, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 6'd17, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_state", 64'({pending, unit_busy}), 64'd0);
    chk("mid_rst_cnt", 64'({stall_cnt, issue_cnt}), 64'd0);
    chk("mid_rst_iss", 64'({iss_alu_valid, iss_mul_valid, iss_lsu_valid, iss_rs1, iss_rs2,
                            iss_rd, iss_imm, iss_ex_type}), 64'd0);
    cyc(); cyc();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
